operand_loader_s2: RTL



---
 rtl/s2_pkg.sv | 19 +
 rtl/operand_bank_ram.sv | 66 ++++++
 rtl/operand_loader_s2.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/s2_pkg.sv
// ---------------------------------------------------------------------------
// s2_pkg
// Shared definitions for the stage-2 operand path.
//   S2_DEPTH       : entries per operand bank (dir_counter sweeps 0..35)
//   S2_BANKS       : number of operand banks (dir selects 0..3)
//   loader_state_t : operand loader FSM states
// ---------------------------------------------------------------------------
package s2_pkg;

    localparam int S2_DEPTH = 36;
    localparam int S2_BANKS = 4;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        ARM       = 2'd1,
        WAIT_DONE = 2'd2
    } loader_state_t;

endpackage : s2_pkg

// File: rtl/operand_bank_ram.sv
// ---------------------------------------------------------------------------
// operand_bank_ram
// Simple dual-port operand store, BANKS x DEPTH words of DATA_W bits, kept as
// one flat array so it maps onto a single block RAM.
//   clk, reset        : clock, synchronous active-high reset (read reg only)
//   wr_en             : write strobe
//   wr_bank, wr_idx   : write bank / entry
//   wr_data           : write data
//   rd_bank, rd_idx   : read bank / entry, presented every cycle
//   rd_data           : registered read data, one cycle after the address;
//                       0 when rd_idx is beyond the bank depth
// ---------------------------------------------------------------------------
module operand_bank_ram
    import s2_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = S2_DEPTH,
    parameter int BANKS  = S2_BANKS,
    parameter int BANK_W = 2,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    localparam int WORDS = BANKS * DEPTH;
    localparam int AW    = $clog2(WORDS);

    logic [DATA_W-1:0] mem [WORDS];
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_data_q;

    // Bank-major flattening: word = bank * DEPTH + entry.
    assign wr_addr     = AW'(wr_bank) * AW'(DEPTH) + AW'(wr_idx);
    assign rd_addr     = AW'(rd_bank) * AW'(DEPTH) + AW'(rd_idx);
    assign rd_in_range = (rd_idx < IDX_W'(DEPTH));

    // Array contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_in_range) begin
            rd_data_q <= mem[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data = rd_data_q;

endmodule : operand_bank_ram

// File: rtl/operand_loader_s2.sv
// ---------------------------------------------------------------------------
// operand_loader_s2
// Stage-2 operand loader. Collects a 144-beat frame from a valid/ready stream
// into 4 banks x 36 entries, pulses data_rdy, then holds the buffer locked
// while the control FSM sweeps it via dir/dir_counter until data_done.
//
// Optional feature macro: LOADER_TIMEOUT_EN -- enables a done-watchdog in
// WAIT_DONE that pulses timeout and returns to LOAD after TIMEOUT_CYC cycles.
// Without it, timeout is tied 0 and WAIT_DONE waits indefinitely.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready : input operand stream
//   data_rdy          : one-cycle pulse, frame stored and ready for sweep
//   data_done         : one-cycle pulse from control FSM, sweep finished
//   dir, dir_counter  : read bank / entry select
//   rd_data           : registered read data (1-cycle latency, 0 if entry>35)
//   frame_err         : one-cycle pulse, frame discarded on bad s_last
//   timeout           : one-cycle pulse, watchdog expired
//   busy              : high while the buffer is locked (ARM, WAIT_DONE)
// ---------------------------------------------------------------------------
module operand_loader_s2
    import s2_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = S2_DEPTH,
    parameter int BANKS       = S2_BANKS,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              data_rdy,
    input  logic              data_done,
    input  logic [1:0]        dir,
    input  logic [5:0]        dir_counter,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_err,
    output logic              timeout,
    output logic              busy
);

    localparam int BANK_W = 2;
    localparam int IDX_W  = 6;

    loader_state_t     state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic              frame_err_q, frame_err_d;
    logic              wr_en;
    logic              last_slot;
    logic              wd_expired;

    assign last_slot = (bank_q == BANK_W'(BANKS - 1)) && (addr_q == IDX_W'(DEPTH - 1));

`ifdef LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;

    // Counts cycles spent in WAIT_DONE; held at zero elsewhere so every
    // entry starts from a clean count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else if (state_q != WAIT_DONE) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    assign wd_expired = (state_q == WAIT_DONE) && (wd_q == WD_W'(TIMEOUT_CYC));
    // A simultaneous data_done takes priority over expiry.
    assign timeout    = wd_expired && !data_done;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign wd_expired         = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            bank_q      <= '0;
            addr_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        addr_d      = addr_q;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            LOAD: begin
                if (s_valid) begin
                    wr_en = 1'b1;
                    if (last_slot) begin
                        bank_d = '0;
                        addr_d = '0;
                        if (s_last) begin
                            state_d = ARM;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        // Early end of frame: restart, leave partial data stale.
                        bank_d      = '0;
                        addr_d      = '0;
                        frame_err_d = 1'b1;
                    end else if (addr_q == IDX_W'(DEPTH - 1)) begin
                        addr_d = '0;
                        bank_d = bank_q + BANK_W'(1);
                    end else begin
                        addr_d = addr_q + IDX_W'(1);
                    end
                end
            end

            ARM: begin
                state_d = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (data_done || wd_expired) begin
                    state_d = LOAD;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign s_ready   = (state_q == LOAD);
    assign data_rdy  = (state_q == ARM);
    assign busy      = (state_q != LOAD);
    assign frame_err = frame_err_q;

    operand_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .BANKS  (BANKS),
        .BANK_W (BANK_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_bank (bank_q),
        .wr_idx  (addr_q),
        .wr_data (s_data),
        .rd_bank (dir),
        .rd_idx  (dir_counter),
        .rd_data (rd_data)
    );

endmodule : operand_loader_s2
